// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Brief    : Shared filterbank constants and types for the subband serializer.
// Revision : 1.0 - initial release
// ============================================================================
package fb_pkg;

  localparam int NUM_CH = 16;
  localparam int DATA_W = 25;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int CNT_W  = 8;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef sample_t frame_t [NUM_CH];

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/subband_frame_buf.sv
`default_nettype none
// ============================================================================
// Module   : subband_frame_buf
// Brief    : One-frame register with load enable and full flag.
// Revision : 1.0 - initial release
// ============================================================================
module subband_frame_buf
  import fb_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   clk_enable,
  input  logic   load,
  input  logic   clear,
  input  frame_t din,
  output frame_t dout,
  output logic   full
);

  frame_t r_data;
  logic   r_full;

  // Load wins over clear so a buffer can be refilled in the cycle it empties.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_full <= 1'b0;
    end else if (clk_enable) begin
      if (load) begin
        r_full <= 1'b1;
      end else if (clear) begin
        r_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clk_enable && load) begin
      r_data <= din;
    end
  end

  assign dout = r_data;
  assign full = r_full;

endmodule
`default_nettype wire

// File: rtl/subband_serializer.sv
`default_nettype none
// ============================================================================
// Module   : subband_serializer
// Brief    : Streams 16-channel subband frames one channel per beat, with a
//            one-frame pending buffer and a saturating dropped-frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module subband_serializer
  import fb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clk_enable,
  input  frame_t            frame_in,
  input  logic              frame_valid,
  output sample_t           out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam logic [CH_W-1:0] c_LAST_CH = CH_W'(NUM_CH - 1);

  ser_state_t        r_state;
  ser_state_t        w_next_state;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   w_next_ch;
  sample_t           r_out_data;
  sample_t           w_next_data;
  logic              r_out_last;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_drop_cnt;

  frame_t w_drain_q;
  frame_t w_pend_q;
  frame_t w_src;
  logic   w_drain_full;
  logic   w_pend_full;
  logic   w_drain_load;
  logic   w_drain_from_pend;
  logic   w_drain_clear;
  logic   w_pend_load;
  logic   w_pend_clear;
  logic   w_direct;
  logic   w_drop;
  logic   w_fv;
  logic   w_accept;

  assign w_fv     = clk_enable & frame_valid;
  assign w_accept = clk_enable & w_drain_full & out_ready;

  always_comb begin
    w_next_state      = r_state;
    w_next_ch         = r_ch;
    w_drain_load      = 1'b0;
    w_drain_from_pend = 1'b0;
    w_drain_clear     = 1'b0;
    w_pend_load       = 1'b0;
    w_pend_clear      = 1'b0;
    w_direct          = 1'b0;
    w_drop            = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fv) begin
          w_drain_load = 1'b1;
          w_next_state = DRAIN;
          w_next_ch    = '0;
        end
      end
      DRAIN: begin
        if (w_accept) begin
          if (r_ch == c_LAST_CH) begin
            w_next_ch = '0;
            if (w_pend_full) begin
              w_drain_load      = 1'b1;
              w_drain_from_pend = 1'b1;
              w_pend_clear      = 1'b1;
            end else if (w_fv) begin
              w_drain_load = 1'b1;
              w_direct     = 1'b1;
            end else begin
              w_drain_clear = 1'b1;
              w_next_state  = IDLE;
            end
          end else begin
            w_next_ch = r_ch + 1'b1;
          end
        end
        // A pending slot being vacated this cycle can take the new frame.
        if (w_fv && !w_direct) begin
          if (!w_pend_full || w_pend_clear) begin
            w_pend_load = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_src[k] = w_drain_from_pend ? w_pend_q[k] : frame_in[k];
    end
  end

  always_comb begin
    w_next_data = '0;
    if (w_drain_load) begin
      w_next_data = w_src[0];
    end else if (w_next_state == DRAIN) begin
      w_next_data = w_drain_q[w_next_ch];
    end
  end

  subband_frame_buf u_drain (
    .clock      (clock),
    .reset      (reset),
    .clk_enable (clk_enable),
    .load       (w_drain_load),
    .clear      (w_drain_clear),
    .din        (w_src),
    .dout       (w_drain_q),
    .full       (w_drain_full)
  );

  subband_frame_buf u_pend (
    .clock      (clock),
    .reset      (reset),
    .clk_enable (clk_enable),
    .load       (w_pend_load),
    .clear      (w_pend_clear),
    .din        (frame_in),
    .dout       (w_pend_q),
    .full       (w_pend_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ch       <= '0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clk_enable) begin
      r_state    <= w_next_state;
      r_ch       <= w_next_ch;
      r_out_data <= w_next_data;
      r_out_last <= (w_next_state == DRAIN) && (w_next_ch == c_LAST_CH);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + 1'b1;
        end
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_ch;
  assign out_last  = r_out_last;
  assign out_valid = w_drain_full;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_subband_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_subband_serializer
// Brief    : Scoreboard bench for subband_serializer with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subband_serializer;
  import fb_pkg::*;

  logic             clock = 1'b0;
  logic             reset;
  logic             clk_enable;
  frame_t           frame_in;
  logic             frame_valid;
  sample_t          out_data;
  logic [CH_W-1:0]  out_ch;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;

  typedef struct {
    int data;
    int ch;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  always #5 clock = ~clock;

  subband_serializer dut (
    .clock       (clock),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_frame(input int base, input int step);
    for (int k = 0; k < NUM_CH; k++) frame_in[k] = sample_t'(base + k * step);
    frame_valid = 1'b1;
  endtask

  task automatic push_frame(input int base, input int step);
    for (int k = 0; k < NUM_CH; k++) exp_q.push_back('{base + k * step, k, k == NUM_CH - 1});
  endtask

  task automatic wait_drain(input int budget);
    out_ready = 1'b1;
    for (int i = 0; i < budget && (exp_q.size() != 0 || out_valid); i++) tick();
    chk("drain_remaining", exp_q.size(), 0);
    chk("drain_valid_low", out_valid, 0);
  endtask

  // Monitor: a beat transfers at the next edge when valid & ready & enable.
  bit    held = 1'b0;
  int    h_data;
  int    h_ch;
  beat_t b;
  always @(negedge clock) begin
    if (reset) begin
      held = 1'b0;
    end else if (clk_enable) begin
      if (held) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, h_data);
        chk("stall_ch", out_ch, h_ch);
      end
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat_ch", out_ch, -1);
          end else begin
            b = exp_q.pop_front();
            chk("beat_data", out_data, b.data);
            chk("beat_ch", out_ch, b.ch);
            chk("beat_last", out_last, b.last);
          end
        end else begin
          held   = 1'b1;
          h_data = out_data;
          h_ch   = out_ch;
        end
      end
    end
  end

  int vcnt;

  initial begin
    reset       = 1'b1;
    clk_enable  = 1'b1;
    frame_valid = 1'b0;
    out_ready   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) frame_in[k] = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_data", out_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);

    // Strobe while disabled is ignored.
    clk_enable = 1'b0;
    drive_frame(1, 1);
    tick();
    frame_valid = 1'b0;
    clk_enable  = 1'b1;
    tick();
    chk("disabled_valid", out_valid, 0);

    // Single frame, ready high: 16 beats starting next cycle.
    out_ready = 1'b1;
    drive_frame(-8000, 1000);
    push_frame(-8000, 1000);
    tick();
    frame_valid = 1'b0;
    chk("lat_valid", out_valid, 1);
    chk("lat_ch", out_ch, 0);
    vcnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (out_valid) vcnt++;
      tick();
    end
    chk("single_beats", vcnt, 16);
    chk("single_end_valid", out_valid, 0);
    chk("single_remaining", exp_q.size(), 0);

    // Back-pressure pattern 1,0,0 repeating.
    drive_frame(500, -37);
    push_frame(500, -37);
    tick();
    frame_valid = 1'b0;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid); i++) begin
      out_ready = (i % 3 == 0);
      tick();
    end
    wait_drain(10);

    // Two frames 5 cycles apart: 32 beats, no bubble.
    out_ready = 1'b1;
    drive_frame(10000, 3);
    push_frame(10000, 3);
    tick();
    frame_valid = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (out_valid) vcnt++;
      if (i == 4) begin
        drive_frame(-20000, 111);
        push_frame(-20000, 111);
      end
      tick();
      frame_valid = 1'b0;
    end
    chk("b2b_beats", vcnt, 32);
    chk("b2b_end_valid", out_valid, 0);

    // Ready low, three frames: third dropped.
    out_ready = 1'b0;
    drive_frame(1000, 1);
    push_frame(1000, 1);
    tick();
    drive_frame(2000, 2);
    push_frame(2000, 2);
    tick();
    drive_frame(3000, 3);
    tick();
    frame_valid = 1'b0;
    tick();
    chk("drop1_overflow", overflow, 1);
    chk("drop1_cnt", drop_cnt, 1);
    chk("drop1_ch", out_ch, 0);
    wait_drain(80);

    // Frame strobe coincident with last-beat accept, pending empty.
    out_ready = 1'b1;
    drive_frame(-300, 7);
    push_frame(-300, 7);
    tick();
    frame_valid = 1'b0;
    for (int i = 0; i < 40 && out_ch != 15; i++) tick();
    chk("direct_pre_ch", out_ch, 15);
    drive_frame(4242, -5);
    push_frame(4242, -5);
    tick();
    frame_valid = 1'b0;
    chk("direct_valid", out_valid, 1);
    chk("direct_ch", out_ch, 0);
    chk("direct_data", out_data, 4242);
    wait_drain(40);

    // Many drops with ready low: counter saturates.
    out_ready = 1'b0;
    drive_frame(77, 1);
    push_frame(77, 1);
    tick();
    drive_frame(88, 1);
    push_frame(88, 1);
    tick();
    for (int i = 0; i < 300; i++) begin
      drive_frame(99, 1);
      tick();
    end
    frame_valid = 1'b0;
    chk("sat_cnt", drop_cnt, 255);
    chk("sat_overflow", overflow, 1);
    wait_drain(80);

    // Reset mid-frame with pending full.
    out_ready = 1'b1;
    drive_frame(600, 10);
    push_frame(600, 10);
    tick();
    drive_frame(700, 10);
    push_frame(700, 10);
    tick();
    frame_valid = 1'b0;
    for (int i = 0; i < 20 && out_ch != 7; i++) tick();
    chk("pre_reset_ch", out_ch, 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    repeat (3) tick();
    chk("post_rst_idle", out_valid, 0);
    drive_frame(-1234, 321);
    push_frame(-1234, 321);
    tick();
    frame_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_ch", out_ch, 0);
    wait_drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
